// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin arbiter sharing one data memory between the datapath and a loader port
//
// Purpose:
//   Grants the single DMem port to either the CPU datapath or the external
//   loader/debug port. Grants last exactly one cycle. A requester cannot be
//   granted in two consecutive cycles, and ties go to whoever was not served
//   last. Read data is registered into the owner's *_rdata with a one-cycle
//   *_valid pulse at the edge that ends the grant.
//
// Optional feature (macro DMEM_ARB_BURST_EN):
//   The loader may hold the memory for up to BURST_LEN back-to-back grants.
//   The default build (macro undefined) has no burst counter.
//
// Ports:
//   clk                  clock, all state updates on the rising edge
//   reset                asynchronous active-low reset
//   cpu_req/cpu_we       datapath request / write(1) or read(0)
//   cpu_addr/cpu_wdata   datapath address / store data
//   cpu_gnt/cpu_valid    datapath grant pulse / read-data-valid pulse
//   cpu_rdata            registered read data for the datapath
//   cpu_stall            cpu_req && !cpu_gnt, to the multicycle controller
//   ld_*                 loader/debug port, same meaning as cpu_* (no stall)
//   mem_addr/wdata/we    to DMem (synchronous write, combinational read)
//   mem_rdata            DMem read data

module dmem_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int BURST_LEN  = 4
) (
  input  logic                  clk,
  input  logic                  reset,

  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_gnt,
  output logic                  cpu_valid,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_stall,

  input  logic                  ld_req,
  input  logic                  ld_we,
  input  logic [ADDR_WIDTH-1:0] ld_addr,
  input  logic [DATA_WIDTH-1:0] ld_wdata,
  output logic                  ld_gnt,
  output logic                  ld_valid,
  output logic [DATA_WIDTH-1:0] ld_rdata,

  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  if (BURST_LEN < 1) begin : g_bad_burst_len
    $error("dmem_arbiter: BURST_LEN must be at least 1");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GNT_CPU = 2'd1,
    GNT_LD  = 2'd2
  } state_t;

  // last_srv encoding: who won the most recent grant
  localparam logic SRV_CPU = 1'b0;
  localparam logic SRV_LD  = 1'b1;

  state_t state;
  state_t next_state;
  logic   last_srv;
  logic   next_srv;
  logic   cpu_elig;
  logic   ld_elig;

`ifdef DMEM_ARB_BURST_EN
  localparam int BCW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  logic [BCW-1:0] burst_cnt;
  logic           burst_hold;

  // Loader keeps the port while it still has beats left in this burst;
  // the CPU request is deliberately ignored here.
  assign burst_hold = (state == GNT_LD) && ld_req &&
                      (burst_cnt < BCW'(BURST_LEN - 1));
`endif

  // Grants come straight from the state register.
  assign cpu_gnt   = (state == GNT_CPU);
  assign ld_gnt    = (state == GNT_LD);
  assign cpu_stall = cpu_req && !cpu_gnt;

  // The requester granted in the current cycle still shows req=1 at the
  // edge ending its grant (it only drops req after that edge), so it is
  // excluded here to avoid serving the same access twice.
  always_comb begin
    cpu_elig   = cpu_req && (state != GNT_CPU);
    ld_elig    = ld_req  && (state != GNT_LD);
    next_state = IDLE;
    next_srv   = last_srv;

    if (cpu_elig && ld_elig) begin
      if (last_srv == SRV_LD) begin
        next_state = GNT_CPU;
        next_srv   = SRV_CPU;
      end else begin
        next_state = GNT_LD;
        next_srv   = SRV_LD;
      end
    end else if (cpu_elig) begin
      next_state = GNT_CPU;
      next_srv   = SRV_CPU;
    end else if (ld_elig) begin
      next_state = GNT_LD;
      next_srv   = SRV_LD;
    end

`ifdef DMEM_ARB_BURST_EN
    if (burst_hold) begin
      next_state = GNT_LD;
      next_srv   = SRV_LD;
    end
`endif
  end

  // Memory port follows the owner during a grant and is parked at zero
  // otherwise; since it decodes the state register, an asynchronous reset
  // drops mem_we immediately and aborts a write in flight.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    case (state)
      GNT_CPU: begin
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_we    = cpu_we;
      end
      GNT_LD: begin
        mem_addr  = ld_addr;
        mem_wdata = ld_wdata;
        mem_we    = ld_we;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      last_srv  <= SRV_LD;
      cpu_valid <= 1'b0;
      ld_valid  <= 1'b0;
      cpu_rdata <= '0;
      ld_rdata  <= '0;
`ifdef DMEM_ARB_BURST_EN
      burst_cnt <= '0;
`endif
    end else begin
      state    <= next_state;
      last_srv <= next_srv;

      // Read data is sampled at the edge ending a read grant; the rdata
      // registers hold their value until the next read by the same owner.
      cpu_valid <= (state == GNT_CPU) && !cpu_we;
      ld_valid  <= (state == GNT_LD)  && !ld_we;
      if ((state == GNT_CPU) && !cpu_we) begin
        cpu_rdata <= mem_rdata;
      end
      if ((state == GNT_LD) && !ld_we) begin
        ld_rdata <= mem_rdata;
      end

`ifdef DMEM_ARB_BURST_EN
      if (burst_hold) begin
        burst_cnt <= burst_cnt + BCW'(1);
      end else begin
        burst_cnt <= '0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - scoreboard bench for dmem_arbiter

module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;

  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [15:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic        cpu_gnt;
  logic        cpu_valid;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;

  logic        ld_req = 1'b0;
  logic        ld_we = 1'b0;
  logic [15:0] ld_addr = '0;
  logic [31:0] ld_wdata = '0;
  logic        ld_gnt;
  logic        ld_valid;
  logic [31:0] ld_rdata;

  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata;

  logic [31:0] mem     [0:65535];
  logic [31:0] ref_mem [0:65535];

  logic [31:0] cpu_q [$];
  logic [31:0] ld_q  [$];
  byte         log_q [$];
  logic        log_en = 1'b0;

  logic        pend_v = 1'b0;
  logic [15:0] pend_a = '0;
  logic [31:0] pend_d = '0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(
    .ADDR_WIDTH(16),
    .DATA_WIDTH(32),
    .BURST_LEN (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .cpu_req  (cpu_req),
    .cpu_we   (cpu_we),
    .cpu_addr (cpu_addr),
    .cpu_wdata(cpu_wdata),
    .cpu_gnt  (cpu_gnt),
    .cpu_valid(cpu_valid),
    .cpu_rdata(cpu_rdata),
    .cpu_stall(cpu_stall),
    .ld_req   (ld_req),
    .ld_we    (ld_we),
    .ld_addr  (ld_addr),
    .ld_wdata (ld_wdata),
    .ld_gnt   (ld_gnt),
    .ld_valid (ld_valid),
    .ld_rdata (ld_rdata),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_we   (mem_we),
    .mem_rdata(mem_rdata)
  );

  // DMem: combinational read, write at the rising edge
  assign mem_rdata = mem[mem_addr];
  initial begin
    forever begin
      @(posedge clk);
      if (mem_we) mem[mem_addr] = mem_wdata;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Monitor: grants push expected read data from the reference memory,
  // valid pulses pop and compare; writes commit to the reference one edge
  // later unless reset intervened.
  initial begin
    forever begin
      @(negedge clk);
      if (pend_v) begin
        if (reset) ref_mem[pend_a] = pend_d;
        pend_v = 1'b0;
      end
      if (cpu_valid) begin
        if (cpu_q.size() == 0) check("cpu_valid_unexpected", 32'(cpu_valid), 32'd0);
        else check("cpu_rdata", cpu_rdata, cpu_q.pop_front());
      end
      if (ld_valid) begin
        if (ld_q.size() == 0) check("ld_valid_unexpected", 32'(ld_valid), 32'd0);
        else check("ld_rdata", ld_rdata, ld_q.pop_front());
      end
      if (cpu_gnt && ld_gnt) check("gnt_exclusive", 32'd1, 32'd0);
      if (cpu_gnt) begin
        check("cpu_mem_addr", 32'(mem_addr), 32'(cpu_addr));
        check("cpu_mem_we", 32'(mem_we), 32'(cpu_we));
        if (cpu_we) begin
          check("cpu_mem_wdata", mem_wdata, cpu_wdata);
          pend_v = 1'b1; pend_a = cpu_addr; pend_d = cpu_wdata;
        end else cpu_q.push_back(ref_mem[cpu_addr]);
      end else if (ld_gnt) begin
        check("ld_mem_addr", 32'(mem_addr), 32'(ld_addr));
        check("ld_mem_we", 32'(mem_we), 32'(ld_we));
        if (ld_we) begin
          check("ld_mem_wdata", mem_wdata, ld_wdata);
          pend_v = 1'b1; pend_a = ld_addr; pend_d = ld_wdata;
        end else ld_q.push_back(ref_mem[ld_addr]);
      end
      if (log_en) log_q.push_back(cpu_gnt ? 8'd67 : (ld_gnt ? 8'd76 : 8'd45));
    end
  end

  // Caller is 1 time unit past a rising edge; returns likewise.
  task automatic cpu_access(input logic we, input logic [15:0] a, input logic [31:0] d);
    logic got;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = cpu_gnt;
    end
    if (!got) check("cpu_gnt_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    cpu_req = 1'b0; cpu_we = 1'b0;
  endtask

  task automatic ld_access(input logic we, input logic [15:0] a, input logic [31:0] d);
    logic got;
    ld_req = 1'b1; ld_we = we; ld_addr = a; ld_wdata = d;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = ld_gnt;
    end
    if (!got) check("ld_gnt_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    ld_req = 1'b0; ld_we = 1'b0;
  endtask

  task automatic do_reset();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    cpu_req = 1'b0; ld_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic check_log(input string tag, input string exp);
    check({tag, "_len"}, 32'(log_q.size()), 32'(exp.len()));
    for (int i = 0; i < exp.len() && i < log_q.size(); i++)
      check($sformatf("%s_%0d", tag, i), 32'(log_q[i]), 32'(exp.getc(i)));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 65536; i++) begin
      mem[i]     = 32'h0000_1000 + i;
      ref_mem[i] = 32'h0000_1000 + i;
    end
    mem[16'h0010] = 32'hDEADBEEF; ref_mem[16'h0010] = 32'hDEADBEEF;
    mem[16'h0008] = 32'h5555_5555; ref_mem[16'h0008] = 32'h5555_5555;

    // Reset values, with a request already pending during reset
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cpu_gnt", 32'(cpu_gnt), 32'd0);
    check("rst_ld_gnt", 32'(ld_gnt), 32'd0);
    check("rst_cpu_valid", 32'(cpu_valid), 32'd0);
    check("rst_ld_valid", 32'(ld_valid), 32'd0);
    check("rst_cpu_rdata", cpu_rdata, 32'd0);
    check("rst_ld_rdata", ld_rdata, 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);

    // Single CPU read straight after reset
    reset = 1'b1;
    #1;
    check("rel_no_gnt", 32'(cpu_gnt), 32'd0);
    check("rel_stall", 32'(cpu_stall), 32'd1);
    @(negedge clk);
    check("rd_gnt", 32'(cpu_gnt), 32'd1);
    check("rd_gnt_stall", 32'(cpu_stall), 32'd0);
    @(posedge clk); #1 cpu_req = 1'b0;
    @(negedge clk);
    check("rd_valid", 32'(cpu_valid), 32'd1);
    check("rd_data", cpu_rdata, 32'hDEADBEEF);
    check("rd_after_gnt", 32'(cpu_gnt), 32'd0);
    check("rd_after_stall", 32'(cpu_stall), 32'd0);
    repeat (3) @(negedge clk);
    check("rdata_hold", cpu_rdata, 32'hDEADBEEF);
    check("valid_one_pulse", 32'(cpu_valid), 32'd0);

    // Loader write then CPU read of the same word
    @(posedge clk); #1;
    ld_access(1'b1, 16'h0004, 32'h1234_5678);
    cpu_access(1'b0, 16'h0004, 32'd0);
    @(negedge clk);
    check("wr_then_rd", cpu_rdata, 32'h1234_5678);

    // CPU alone holding req: one idle cycle between its grants
    @(posedge clk); #1;
    log_q.delete(); log_en = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
    repeat (6) @(negedge clk);
    log_en = 1'b0;
    @(posedge clk); #1 cpu_req = 1'b0;
    check_log("cpu_alone", "-C-C-C");

    // Simultaneous requests after reset: CPU wins the first tie
    do_reset();
    log_q.delete(); log_en = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0020;
    ld_req  = 1'b1; ld_we  = 1'b0; ld_addr  = 16'h0030;
    repeat (7) @(negedge clk);
    log_en = 1'b0;
    @(posedge clk); #1 cpu_req = 1'b0; ld_req = 1'b0;
`ifdef DMEM_ARB_BURST_EN
    check_log("tie_alt", "-CLLLLC");
`else
    check_log("tie_alt", "-CLCLCL");
`endif

    // Loader writes words 0..3 while the CPU wants a read
    do_reset();
    log_q.delete(); log_en = 1'b1;
    fork
      begin
        for (int b = 0; b < 4; b++) ld_access(1'b1, 16'(b), 32'hB000_0000 + b);
      end
      begin
        @(posedge clk); #1;
        cpu_access(1'b0, 16'h0040, 32'd0);
      end
    join
    log_en = 1'b0;
`ifdef DMEM_ARB_BURST_EN
    check_log("burst", "-LLLLC");
`else
    check_log("burst", "-LCL-L-L");
`endif
    cpu_access(1'b0, 16'h0003, 32'd0);
    @(negedge clk);
    check("burst_word3", cpu_rdata, 32'hB000_0003);

    // Reset in the middle of a CPU write grant
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0008; cpu_wdata = 32'hAAAA_0000;
    begin
      logic got;
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
        @(negedge clk);
        got = cpu_gnt;
      end
      check("wr_gnt_seen", 32'(got), 32'd1);
    end
    #2 reset = 1'b0;
    #1;
    check("abort_mem_we", 32'(mem_we), 32'd0);
    check("abort_cpu_gnt", 32'(cpu_gnt), 32'd0);
    check("abort_mem_addr", 32'(mem_addr), 32'd0);
    check("abort_mem_wdata", mem_wdata, 32'd0);
    check("abort_cpu_rdata", cpu_rdata, 32'd0);
    @(posedge clk); #1 cpu_req = 1'b0; cpu_we = 1'b0;
    @(negedge clk);
    check("abort_mem8", mem[16'h0008], 32'h5555_5555);
    reset = 1'b1;
    @(posedge clk); #1;
    cpu_access(1'b0, 16'h0008, 32'd0);
    @(negedge clk);
    check("abort_rd8", cpu_rdata, 32'h5555_5555);

    // Idle bus for 20 cycles
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_mem_we", 32'(mem_we), 32'd0);
      check("idle_mem_addr", 32'(mem_addr), 32'd0);
      check("idle_pulses", 32'({cpu_gnt, ld_gnt, cpu_valid, ld_valid}), 32'd0);
    end

    check("cpu_q_empty", 32'(cpu_q.size()), 32'd0);
    check("ld_q_empty", 32'(ld_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
